// File: rtl/sld_loader.sv
// sld_loader: streams DATA_LEN bytes from a byte ROM to a UART transmitter
// once SYNC_BYTE is received. It handshakes with the transmitter through
// tx_start / tx_busy, so only one byte is ever in flight.
//
// Ports:
//   clk_i, rst_i     single clock, synchronous active-high reset
//   rx_data_i        byte from the UART receiver, qualified by rx_valid_i
//   mem_addr_o       registered ROM read address
//   mem_data_i       ROM read data, valid one cycle after mem_addr_o
//   tx_data_o        registered byte to the UART transmitter
//   tx_start_o       one-cycle start pulse to the transmitter
//   tx_busy_i        transmitter busy flag
//   rearm_i          returns the block from DONE to IDLE
//   active_o         high in every state except IDLE and DONE
//   done_o           high while in DONE
//   sent_count_o     bytes completed in the current session
module sld_loader #(
  parameter int unsigned DATA_LEN  = 910,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  input  logic              rearm_i,
  output logic              active_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] sent_count_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DATA_LEN - 1);
  localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWaitHi,
    StWaitLo,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] sent_count_q, sent_count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      mem_addr_q   <= '0;
      sent_count_q <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mem_addr_q   <= mem_addr_d;
      sent_count_q <= sent_count_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mem_addr_d   = mem_addr_q;
    sent_count_d = sent_count_q;
    tx_data_d    = tx_data_q;
    // Start is a pulse: it only rises on the LOAD -> WAIT_HI transition.
    tx_start_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
          idx_d        = '0;
          mem_addr_d   = '0;
          sent_count_d = '0;
          state_d      = StFetch;
        end
      end
      // One cycle for the synchronous ROM to present mem_data_i.
      StFetch: state_d = StLoad;
      StLoad: begin
        if (!tx_busy_i) begin
          tx_data_d  = mem_data_i;
          tx_start_d = 1'b1;
          state_d    = StWaitHi;
        end
      end
      // Wait for the transmitter to acknowledge the start before watching
      // for its falling busy edge, so a byte is never counted twice.
      StWaitHi: begin
        if (tx_busy_i) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!tx_busy_i) begin
          sent_count_d = sent_count_q + One;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d      = idx_q + One;
            mem_addr_d = idx_q + One;
            state_d    = StFetch;
          end
        end
      end
      StDone: begin
        if (rearm_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr_o   = mem_addr_q;
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign sent_count_o = sent_count_q;
  assign active_o     = (state_q != StIdle) && (state_q != StDone);
  assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_sld_loader.sv
// Bench for sld_loader: a 4-byte session instance and a 1-byte instance,
// each with a synchronous ROM and a behavioural UART transmitter model.
// Expected bytes are queued when a session is triggered and compared on
// every tx_start pulse.
module tb_sld_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid0, rx_valid1, rearm0, rearm1, force_busy;

  logic [9:0] addr0, addr1, cnt0, cnt1;
  logic [7:0] md0, md1, txd0, txd1;
  logic       st0, st1, act0, act1, dn0, dn1;
  logic       ub0, ub1;
  int         uc0 = 0, uc1 = 0;

  logic [7:0] rom [4];

  sld_loader #(.DATA_LEN(4)) dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid0),
    .mem_addr_o  (addr0),
    .mem_data_i  (md0),
    .tx_data_o   (txd0),
    .tx_start_o  (st0),
    .tx_busy_i   (ub0 | force_busy),
    .rearm_i     (rearm0),
    .active_o    (act0),
    .done_o      (dn0),
    .sent_count_o(cnt0)
  );

  sld_loader #(.DATA_LEN(1)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid1),
    .mem_addr_o  (addr1),
    .mem_data_i  (md1),
    .tx_data_o   (txd1),
    .tx_start_o  (st1),
    .tx_busy_i   (ub1),
    .rearm_i     (rearm1),
    .active_o    (act1),
    .done_o      (dn1),
    .sent_count_o(cnt1)
  );

  // Synchronous ROMs.
  always @(posedge clk) begin
    md0 <= rom[addr0[1:0]];
    md1 <= rom[addr1[1:0]];
  end

  // UART tx models: busy rises the edge after start, stays high 10 cycles.
  always @(posedge clk) begin
    if (rst) begin
      ub0 <= 1'b0; uc0 <= 0;
    end else if (st0) begin
      ub0 <= 1'b1; uc0 <= 10;
    end else if (uc0 != 0) begin
      uc0 <= uc0 - 1;
      if (uc0 == 1) ub0 <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      ub1 <= 1'b0; uc1 <= 0;
    end else if (st1) begin
      ub1 <= 1'b1; uc1 <= 10;
    end else if (uc1 != 0) begin
      uc1 <= uc1 - 1;
      if (uc1 == 1) ub1 <= 1'b0;
    end
  end

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic [9:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_start0 = 0;
  logic prev_st0 = 1'b0;
  logic prev_st1 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the 4-byte instance.
  always @(negedge clk) begin
    exp_t e;
    if (st0 === 1'b1) begin
      n_start0++;
      check_eq("start0_single_pulse", {31'd0, prev_st0}, 32'd0);
      check_eq("q0_has_entry", (q0.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check_eq("tx_data0", {24'd0, txd0}, {24'd0, e.data});
        check_eq("mem_addr0", {22'd0, addr0}, {22'd0, e.addr});
        check_eq("sent_count0_at_start", {22'd0, cnt0}, {22'd0, e.cnt});
      end
    end
    prev_st0 = st0;
  end

  // Scoreboard for the 1-byte instance.
  always @(negedge clk) begin
    exp_t e;
    if (st1 === 1'b1) begin
      check_eq("start1_single_pulse", {31'd0, prev_st1}, 32'd0);
      check_eq("q1_has_entry", (q1.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check_eq("tx_data1", {24'd0, txd1}, {24'd0, e.data});
        check_eq("mem_addr1", {22'd0, addr1}, {22'd0, e.addr});
      end
    end
    prev_st1 = st1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx0(input logic [7:0] b);
    rx_data   = b;
    rx_valid0 = 1'b1;
    tick();
    rx_valid0 = 1'b0;
  endtask

  task automatic push_session0();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr = 10'(k);
      e.data = rom[k];
      e.cnt  = 10'(k);
      q0.push_back(e);
    end
  endtask

  task automatic wait_done0(input int bound);
    int n = 0;
    while (dn0 !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check_eq("done0_reached", {31'd0, dn0}, 32'd1);
  endtask

  task automatic rearm_pulse0();
    rearm0 = 1'b1;
    tick();
    rearm0 = 1'b0;
  endtask

  task automatic check_reset0(input string tag);
    check_eq({tag, "_active"},   {31'd0, act0}, 32'd0);
    check_eq({tag, "_done"},     {31'd0, dn0},  32'd0);
    check_eq({tag, "_tx_start"}, {31'd0, st0},  32'd0);
    check_eq({tag, "_mem_addr"}, {22'd0, addr0}, 32'd0);
    check_eq({tag, "_sent"},     {22'd0, cnt0}, 32'd0);
    check_eq({tag, "_tx_data"},  {24'd0, txd0}, 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int starts_before;
    exp_t e;

    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
    rst = 1'b1; rx_data = 8'h00; rx_valid0 = 1'b0; rx_valid1 = 1'b0;
    rearm0 = 1'b0; rearm1 = 1'b0; force_busy = 1'b0;
    repeat (3) tick();
    check_reset0("reset");
    rst = 1'b0;

    // Non-sync byte is ignored.
    send_rx0(8'h55);
    repeat (6) tick();
    check_eq("no_activity_after_55", {31'd0, act0}, 32'd0);
    check_eq("no_start_after_55", n_start0, 0);

    // Trigger; rx_valid sampled at edge E, tx_start visible after E+2.
    push_session0();
    rx_data   = 8'hAA;
    rx_valid0 = 1'b1;
    tick();
    rx_valid0 = 1'b0;
    lat = 1;
    while (st0 !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check_eq("trigger_latency", lat, 3);
    check_eq("active_in_session", {31'd0, act0}, 32'd1);

    // Mid-session sync byte and rearm must both be ignored.
    repeat (20) tick();
    rx_data   = 8'hAA;
    rx_valid0 = 1'b1;
    rearm0    = 1'b1;
    tick();
    rx_valid0 = 1'b0;
    rearm0    = 1'b0;
    check_eq("rearm_ignored_active", {31'd0, act0}, 32'd1);
    wait_done0(300);
    check_eq("s1_sent_count", {22'd0, cnt0}, 32'd4);
    check_eq("s1_active_low", {31'd0, act0}, 32'd0);
    check_eq("s1_queue_empty", q0.size(), 0);
    check_eq("s1_start_count", n_start0, 4);
    repeat (5) tick();
    check_eq("done_held", {31'd0, dn0}, 32'd1);
    check_eq("sent_held", {22'd0, cnt0}, 32'd4);
    rearm_pulse0();
    check_eq("rearm_done_low", {31'd0, dn0}, 32'd0);
    check_eq("rearm_idle", {31'd0, act0}, 32'd0);

    // Transmitter busy at trigger: LOAD must hold.
    force_busy = 1'b1;
    push_session0();
    send_rx0(8'hAA);
    starts_before = n_start0;
    repeat (20) tick();
    check_eq("busy_hold_no_start", n_start0, starts_before);
    check_eq("busy_hold_active", {31'd0, act0}, 32'd1);
    check_eq("busy_hold_addr", {22'd0, addr0}, 32'd0);
    force_busy = 1'b0;
    wait_done0(300);
    check_eq("s2_start_count", n_start0, starts_before + 4);
    check_eq("s2_sent_count", {22'd0, cnt0}, 32'd4);
    check_eq("s2_queue_empty", q0.size(), 0);
    rearm_pulse0();

    // Reset after byte 2 aborts the session.
    push_session0();
    send_rx0(8'hAA);
    n = 0;
    while (cnt0 != 10'd2 && n < 300) begin
      tick();
      n++;
    end
    check_eq("reach_byte2", {22'd0, cnt0}, 32'd2);
    rst = 1'b1;
    tick();
    check_reset0("midrst");
    q0.delete();
    rst = 1'b0;
    tick();
    push_session0();
    send_rx0(8'hAA);
    wait_done0(300);
    check_eq("s3_sent_count", {22'd0, cnt0}, 32'd4);
    check_eq("s3_queue_empty", q0.size(), 0);
    rearm_pulse0();

    // DATA_LEN=1 instance.
    e.addr = 10'd0; e.data = 8'h11; e.cnt = 10'd0;
    q1.push_back(e);
    rx_data   = 8'hAA;
    rx_valid1 = 1'b1;
    tick();
    rx_valid1 = 1'b0;
    n = 0;
    while (dn1 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq("len1_done", {31'd0, dn1}, 32'd1);
    check_eq("len1_sent_count", {22'd0, cnt1}, 32'd1);
    check_eq("len1_queue_empty", q1.size(), 0);
    check_eq("len1_active_low", {31'd0, act1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
